// File: rtl/sys_gpio_pkg.sv
// Shared constants for the GPIO input block: register word addresses, edge-type
// encodings and the edge-match helper used by the detector.
package sys_gpio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  function automatic logic [31:0] edge_hits(input logic [31:0] cur,
                                            input logic [31:0] prev,
                                            input int unsigned edge_type);
    logic [31:0] hits;
    case (edge_type)
      EDGE_RISING:  hits = cur & ~prev;
      EDGE_FALLING: hits = ~cur & prev;
      default:      hits = cur ^ prev;
    endcase
    return hits;
  endfunction

endpackage

// File: rtl/sys_gpio_edge_det.sv
// Per-bit input stage and edge detector; define SYS_GPIO_IN_SYNC_EN to insert a
// two-flop synchronizer ahead of the sample register (3 clk input-to-sample).
module sys_gpio_edge_det
  import sys_gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] stage_data;
  logic             stage_vld;

`ifdef SYS_GPIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [1:0]       sync_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_vld_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  assign stage_data = sync2_q;
  assign stage_vld  = sync_vld_q[1];
`else
  assign stage_data = in_port;
  assign stage_vld  = 1'b1;
`endif

  logic [WIDTH-1:0] s_q, prev_q;
  logic             s_vld_q, armed_q;

  // armed trails the first real sample by one clk so prev is also real data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      prev_q  <= '0;
      s_vld_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s_q     <= stage_data;
      prev_q  <= s_q;
      s_vld_q <= stage_vld;
      armed_q <= s_vld_q;
    end
  end

  logic [31:0] hits;

  assign hits  = edge_hits(32'(s_q), 32'(prev_q), EDGE_TYPE);
  assign data  = s_q;
  assign edges = armed_q ? hits[WIDTH-1:0] : '0;

endmodule

// File: rtl/sys_gpio_a_in.sv
// Avalon-MM GPIO input port with sticky edge capture and masked level irq.
// Optional input synchronizer enabled by defining SYS_GPIO_IN_SYNC_EN.
module sys_gpio_a_in
  import sys_gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] edges;

  sys_gpio_edge_det #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_det (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .data    (data),
    .edges   (edges)
  );

  logic [WIDTH-1:0] irq_mask_q, edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, rd_mux;
  logic             irq_q;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] clr;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

  always_comb begin
    clr = '0;
    if (wr_en && address == ADDR_EDGE_CAP) begin
      clr = writedata[WIDTH-1:0];
    end
    // New edges win over a same-cycle clear.
    edge_cap_d = (edge_cap_q & ~clr) | edges;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = data;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edge_cap_q <= edge_cap_d;
      irq_q      <= |(edge_cap_q & irq_mask_q);
      if (wr_en && address == ADDR_IRQ_MASK) begin
        irq_mask_q <= writedata[WIDTH-1:0];
      end
      if (rd_en) begin
        readdata_q <= rd_mux;
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sys_gpio_a_in.sv
// Bench for sys_gpio_a_in: rising, falling and any-edge instances share one bus,
// checked by directed scenarios and a random run against a history-based model.
module tb_sys_gpio_a_in;

`ifdef SYS_GPIO_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] in_port = '0;
  logic [31:0] rd [3];
  logic        irq_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sys_gpio_a_in #(.WIDTH(32), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_v[0])
  );
  sys_gpio_a_in #(.WIDTH(32), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_v[1])
  );
  sys_gpio_a_in #(.WIDTH(32), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_v[2])
  );

  // Reference model: the sample seen by the block is the input LAT edges ago.
  logic [31:0] hist [LAT+1];
  int          cnt;
  logic [31:0] m_ec [3];
  logic [31:0] m_rd [3];
  logic        m_irq [3];
  logic [31:0] m_mask;
  logic [31:0] s_cur, prev_cur, clr_m, ev;
  logic        armed_m;

  function automatic logic [31:0] edge_of(input int t, input logic [31:0] c,
                                          input logic [31:0] p);
    if (t == 0) return c & ~p;
    if (t == 1) return ~c & p;
    return c ^ p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt = 0;
      m_mask = '0;
      for (int k = 0; k <= LAT; k++) hist[k] = '0;
      for (int t = 0; t < 3; t++) begin
        m_ec[t] = '0;
        m_rd[t] = '0;
        m_irq[t] = 1'b0;
      end
    end else begin
      s_cur    = (cnt >= LAT) ? hist[LAT-1] : '0;
      prev_cur = (cnt >= LAT + 1) ? hist[LAT] : '0;
      armed_m  = (cnt >= LAT + 1);
      clr_m    = (chipselect && !write_n && address == 3'd3) ? writedata : '0;
      for (int t = 0; t < 3; t++) begin
        ev = armed_m ? edge_of(t, s_cur, prev_cur) : '0;
        m_irq[t] = |(m_ec[t] & m_mask);
        if (chipselect && write_n) begin
          case (address)
            3'd0:    m_rd[t] = s_cur;
            3'd2:    m_rd[t] = m_mask;
            3'd3:    m_rd[t] = m_ec[t];
            default: m_rd[t] = '0;
          endcase
        end
        m_ec[t] = (m_ec[t] & ~clr_m) | ev;
      end
      if (chipselect && !write_n && address == 3'd2) m_mask = writedata;
      for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_port;
      if (cnt < 15) cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_read(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    step();
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    in_port = 32'hFFFF_FFFF;
    reset = 1'b1;
    step();
    checks++;
    if (rd[0] !== 32'h0 || irq_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rd=%h irq=%b want rd=0 irq=0", rd[0], irq_v[0]);
    end
    step();
    reset = 1'b0;
    repeat (LAT + 3) step();
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (irq_v[t] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_irq inst=%0d got=%b want=0", t, irq_v[t]);
      end
    end
    do_read(3'd3);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (rd[t] !== 32'h0) begin
        errors++;
        $display("FAIL reset_release_edge_cap inst=%0d got=%h want=0", t, rd[t]);
      end
    end
    do_read(3'd0);
    checks++;
    if (rd[0] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_read_data got=%h want=ffffffff", rd[0]);
    end
  endtask

  task automatic test_rising_irq();
    in_port = 32'h0;
    repeat (LAT + 3) step();
    do_write(3'd3, 32'hFFFF_FFFF);
    do_write(3'd2, 32'h0000_0001);
    in_port = 32'h0000_0001;
    repeat (LAT + 1) step();
    checks++;
    if (irq_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_early got=%b want=0", irq_v[0]);
    end
    step();
    checks++;
    if (irq_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rise_irq_latency got=%b want=1", irq_v[0]);
    end
    do_read(3'd3);
    checks++;
    if (rd[0] !== 32'h1) begin
      errors++;
      $display("FAIL rise_edge_cap got=%h want=00000001", rd[0]);
    end
  endtask

  task automatic test_clear();
    do_write(3'd3, 32'h0);
    do_read(3'd3);
    checks++;
    if (rd[0] !== 32'h1 || irq_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_zero_noop rd=%h irq=%b want rd=00000001 irq=1", rd[0], irq_v[0]);
    end
    do_write(3'd3, 32'h1);
    do_read(3'd3);
    checks++;
    if (rd[0] !== 32'h0 || irq_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_w1c rd=%h irq=%b want rd=0 irq=0", rd[0], irq_v[0]);
    end
  endtask

  task automatic test_set_priority();
    in_port = 32'h0000_0011;
    repeat (LAT) step();
    do_write(3'd3, 32'h0000_0010);
    do_read(3'd3);
    checks++;
    if (rd[0] !== 32'h0000_0010) begin
      errors++;
      $display("FAIL set_priority got=%h want=00000010", rd[0]);
    end
  endtask

  task automatic test_any_edge();
    do_write(3'd2, 32'h0);
    in_port = 32'h0000_0080;
    repeat (LAT + 3) step();
    do_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'h0;
    repeat (LAT + 3) step();
    do_read(3'd3);
    checks++;
    if (rd[2] !== 32'h0000_0080 || irq_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL any_edge_cap rd=%h irq=%b want rd=00000080 irq=0", rd[2], irq_v[2]);
    end
    checks++;
    if (rd[0] !== 32'h0 || rd[1] !== 32'h0000_0080) begin
      errors++;
      $display("FAIL fall_vs_rise_cap rise=%h fall=%h want rise=0 fall=00000080", rd[0], rd[1]);
    end
    do_write(3'd2, 32'h0000_0080);
    checks++;
    if (irq_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL mask_irq_early got=%b want=0", irq_v[2]);
    end
    step();
    checks++;
    if (irq_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL mask_irq got=%b want=1", irq_v[2]);
    end
  endtask

  task automatic test_unmapped();
    do_read(3'd2);
    checks++;
    if (rd[2] !== 32'h0000_0080) begin
      errors++;
      $display("FAIL read_mask got=%h want=00000080", rd[2]);
    end
    do_read(3'd1);
    checks++;
    if (rd[2] !== 32'h0) begin
      errors++;
      $display("FAIL read_addr1 got=%h want=0", rd[2]);
    end
    do_read(3'd2);
    do_read(3'd5);
    checks++;
    if (rd[2] !== 32'h0) begin
      errors++;
      $display("FAIL read_addr5 got=%h want=0", rd[2]);
    end
    chipselect = 1'b1; write_n = 1'b1; address = 3'd3;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (rd[2] !== 32'h0 || irq_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read rd=%h irq=%b want rd=0 irq=0", rd[2], irq_v[2]);
    end
    chipselect = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (rd[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_rd got=%h want=0", rd[2]);
    end
  endtask

  task automatic test_random();
    int op;
    in_port = $urandom;
    for (int i = 0; i < 400; i++) begin
      in_port = in_port ^ ($urandom & $urandom & $urandom);
      op = $urandom_range(0, 3);
      chipselect = (op != 0);
      write_n = (op == 1);
      address = (op == 1) ? 3'($urandom_range(0, 7)) : ((op == 2) ? 3'd2 : 3'd3);
      writedata = (op == 3) ? ($urandom & $urandom) : $urandom;
      step();
      chipselect = 1'b0; write_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
        checks++;
        if (rd[t] !== m_rd[t] || irq_v[t] !== m_irq[t]) begin
          errors++;
          $display("FAIL random cyc=%0d inst=%0d rd=%h irq=%b want rd=%h irq=%b",
                   i, t, rd[t], irq_v[t], m_rd[t], m_irq[t]);
        end
      end
      if (i == 200) begin
        reset = 1'b1;
        #1;
        checks++;
        if (rd[2] !== 32'h0 || irq_v[2] !== 1'b0) begin
          errors++;
          $display("FAIL random_reset rd=%h irq=%b want rd=0 irq=0", rd[2], irq_v[2]);
        end
        step();
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising_irq();
    test_clear();
    test_set_priority();
    test_any_edge();
    test_unmapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_gpio_a_in.md
SYS_GPIO_A_IN -- requirements
Module: sys_gpio_a_in

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning input port and data width (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0, meaning capture edge: 0 rising, 1 falling, 2 any.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port address  input  3  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port in_port  input  WIDTH  external GPIO inputs, asynchronous to clk.
REQ-010 SHALL have port readdata  output  32  registered read data; bits above WIDTH are 0.
REQ-011 SHALL have port irq  output  1  active-high level interrupt.

Function
REQ-012 SHALL sample in_port through the input stage (REQ-027/028) into sampled data s; prev holds s delayed one clk.
REQ-013 SHALL register map: addr 0 data (RO, s), addr 2 irq_mask (RW), addr 3 edge_capture (RW1C); other addresses read 0, writes ignored.
REQ-014 SHALL treat a write as chipselect=1 and write_n=0 in the same cycle; a read as chipselect=1 and write_n=1.
REQ-015 SHALL present readdata one clk after the read cycle (read latency 1); readdata holds its value when not reading.
REQ-016 SHALL set edge_capture[i] when bit i of s vs prev matches EDGE_TYPE and the armed flag is 1.
REQ-017 SHALL clear edge_capture[i] on a write to addr 3 with writedata[i]=1; zero bits unaffected.
REQ-018 SHALL give set priority: edge and clear on the same bit in the same cycle leaves the bit 1.
REQ-019 SHALL keep edge_capture bits sticky until cleared; no counter, no overflow indication.
REQ-020 SHALL drive irq = OR of (edge_capture AND irq_mask), registered, one clk after the causing state change.
REQ-021 SHALL set armed one clk after the first valid sample following reset; no edges detected before armed.
REQ-022 SHALL make irq_mask writes take effect on irq in the cycle after the write.

Reset
REQ-023 SHALL on reset assertion immediately clear s, prev, edge_capture, irq_mask, armed, readdata and irq to 0.
REQ-024 SHALL, on reset mid-operation, discard pending edges and in-flight reads; readdata 0 the cycle after release.
REQ-025 SHALL not flag an edge for inputs already high at reset release (armed gating).
REQ-026 SHALL require no reset synchronizer inside the block; reset release synchronization is the system's job.

Configuration
REQ-027 SHALL, with SYS_GPIO_IN_SYNC_EN defined, pass in_port through a two-flop synchronizer before s (input-to-s latency 3 clk).
REQ-028 SHALL, without SYS_GPIO_IN_SYNC_EN, register in_port once into s (latency 1 clk); register map and irq behaviour unchanged.

Structure
REQ-029 SHALL place register address constants (ADDR_DATA=0, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3) and EDGE_TYPE encodings in shared package sys_gpio_pkg.
REQ-030 SHALL implement per-bit sync and edge detection in one sub-module sys_gpio_edge_det, instantiated once WIDTH wide.

Verification
REQ-031 SHALL check: reset with in_port=32'hFFFF_FFFF, release -> edge_capture 0, irq 0, read addr 0 returns 32'hFFFF_FFFF.
REQ-032 SHALL check: EDGE_TYPE 0, irq_mask=32'h0000_0001, in_port[0] 0->1 -> edge_capture=32'h1, irq=1 at expected latency per macro.
REQ-033 SHALL check: write 32'h1 to addr 3 -> edge_capture 0, irq deasserts next clk; write 32'h0 to addr 3 -> no change.
REQ-034 SHALL check: edge on bit 4 in same cycle as clear of bit 4 -> edge_capture[4] stays 1.
REQ-035 SHALL check: EDGE_TYPE 2, toggle in_port[7] 1->0 with irq_mask 0 -> edge_capture=32'h80, irq 0; then mask 32'h80 -> irq 1 next clk.
REQ-036 SHALL check: read addr 1 and addr 5 -> readdata 0; reset asserted mid-read -> readdata 0 immediately.
